// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the femto req/resp bus.
// Buffers one request per master and issues one transaction at a time.
module bus_arbiter #(
  parameter int XLEN      = 32,
  parameter int BUS_WIDTH = 32,
  parameter int ACC_W     = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [XLEN-1:0]      m0_addr,
  input  logic                 m0_w_rb,
  input  logic [ACC_W-1:0]     m0_acc,
  input  logic [BUS_WIDTH-1:0] m0_wdata,
  input  logic                 m0_req,
  output logic [BUS_WIDTH-1:0] m0_rdata,
  output logic                 m0_resp,
  output logic                 m0_fault,
  input  logic [XLEN-1:0]      m1_addr,
  input  logic                 m1_w_rb,
  input  logic [ACC_W-1:0]     m1_acc,
  input  logic [BUS_WIDTH-1:0] m1_wdata,
  input  logic                 m1_req,
  output logic [BUS_WIDTH-1:0] m1_rdata,
  output logic                 m1_resp,
  output logic                 m1_fault,
  output logic [XLEN-1:0]      s_addr,
  output logic                 s_w_rb,
  output logic [ACC_W-1:0]     s_acc,
  output logic [BUS_WIDTH-1:0] s_wdata,
  output logic                 s_req,
  input  logic [BUS_WIDTH-1:0] s_rdata,
  input  logic                 s_resp,
  input  logic                 s_fault
);

  typedef struct packed {
    logic [XLEN-1:0]      addr;
    logic                 w_rb;
    logic [ACC_W-1:0]     acc;
    logic [BUS_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    pend_q, pend_d;
  req_t          buf0_q, buf0_d;
  req_t          buf1_q, buf1_d;
  req_t          sel;
  logic          done_resp;
  logic          done_fault;
  logic          s_req_c;
  logic          winner;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
      pend_q  <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    timer_d    = timer_q;
    s_req_c    = 1'b0;
    done_resp  = 1'b0;
    done_fault = 1'b0;
    winner     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          unique case (1'b1)
            (pend_q == 2'b11): winner = ~last_q;
            default:           winner = pend_q[1];
          endcase
          owner_d = winner;
          last_d  = winner;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        s_req_c = 1'b1;
        timer_d = '0;
        if (s_fault) begin
          done_fault = 1'b1;
          state_d    = IDLE;
        end else if (s_resp) begin
          done_resp = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (s_resp) begin
          done_resp = 1'b1;
          state_d   = IDLE;
        end else if (TIMEOUT != 0 && timer_q == TLAST) begin
          done_fault = 1'b1;
          state_d    = IDLE;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A completing master cannot re-request in the same cycle: pend is still set.
  always_comb begin
    pend_d = pend_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if ((done_resp || done_fault) && !owner_q) begin
      pend_d[0] = 1'b0;
    end else if (m0_req && !pend_q[0]) begin
      pend_d[0] = 1'b1;
      buf0_d    = '{m0_addr, m0_w_rb, m0_acc, m0_wdata};
    end
    if ((done_resp || done_fault) && owner_q) begin
      pend_d[1] = 1'b0;
    end else if (m1_req && !pend_q[1]) begin
      pend_d[1] = 1'b1;
      buf1_d    = '{m1_addr, m1_w_rb, m1_acc, m1_wdata};
    end
  end

  assign sel      = owner_q ? buf1_q : buf0_q;
  assign s_addr   = sel.addr;
  assign s_w_rb   = sel.w_rb;
  assign s_acc    = sel.acc;
  assign s_wdata  = sel.wdata;
  assign s_req    = s_req_c;
  assign m0_resp  = done_resp & ~owner_q;
  assign m1_resp  = done_resp & owner_q;
  assign m0_fault = done_fault & ~owner_q;
  assign m1_fault = done_fault & owner_q;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: latency, round-robin,
// fault, timeout and reset-during-wait scenarios.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        m0_w_rb = 1'b0, m1_w_rb = 1'b0;
  logic [1:0]  m0_acc = '0, m1_acc = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_resp, m1_resp, m0_fault, m1_fault;
  logic [31:0] s_addr, s_wdata;
  logic        s_w_rb, s_req;
  logic [1:0]  s_acc;
  logic [31:0] s_rdata = '0;
  logic        s_resp = 1'b0, s_fault = 1'b0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .XLEN(32), .BUS_WIDTH(32), .ACC_W(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc),
    .m0_wdata(m0_wdata), .m0_req(m0_req), .m0_rdata(m0_rdata),
    .m0_resp(m0_resp), .m0_fault(m0_fault),
    .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc),
    .m1_wdata(m1_wdata), .m1_req(m1_req), .m1_rdata(m1_rdata),
    .m1_resp(m1_resp), .m1_fault(m1_fault),
    .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc),
    .s_wdata(s_wdata), .s_req(s_req), .s_rdata(s_rdata),
    .s_resp(s_resp), .s_fault(s_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    nvec++; if (s_req !== 1'b0) begin nerr++; $display("FAIL rst_s_req: got %b want 0", s_req); end
    nvec++; if ({m0_resp, m1_resp} !== 2'b00) begin nerr++; $display("FAIL rst_resp: got %b want 00", {m0_resp, m1_resp}); end
    nvec++; if ({m0_fault, m1_fault} !== 2'b00) begin nerr++; $display("FAIL rst_fault: got %b want 00", {m0_fault, m1_fault}); end
    nvec++; if (s_addr !== 32'h0) begin nerr++; $display("FAIL rst_s_addr: got %h want 0", s_addr); end
    tick();
    tick();
    rstn = 1'b1;
    #1;
    nvec++; if (s_req !== 1'b0) begin nerr++; $display("FAIL rst_rel_s_req: got %b want 0", s_req); end
  endtask

  task automatic test_basic_read();
    tick();
    m0_addr = 32'h0000_1000; m0_w_rb = 1'b0; m0_acc = 2'd2; m0_req = 1'b1;
    #1;
    nvec++; if (s_req !== 1'b0) begin nerr++; $display("FAIL rd_T0_s_req: got %b want 0", s_req); end
    tick();
    m0_req = 1'b0;
    #1;
    nvec++; if (s_req !== 1'b0) begin nerr++; $display("FAIL rd_T1_s_req: got %b want 0", s_req); end
    tick();
    #1;
    nvec++; if (s_req !== 1'b1) begin nerr++; $display("FAIL rd_T2_s_req: got %b want 1", s_req); end
    nvec++; if (s_addr !== 32'h0000_1000) begin nerr++; $display("FAIL rd_s_addr: got %h want 00001000", s_addr); end
    nvec++; if ({s_w_rb, s_acc} !== 3'b0_10) begin nerr++; $display("FAIL rd_wrb_acc: got %b want 010", {s_w_rb, s_acc}); end
    tick();
    #1;
    nvec++; if ({s_req, m0_resp} !== 2'b00) begin nerr++; $display("FAIL rd_T3_wait: got %b want 00", {s_req, m0_resp}); end
    tick();
    s_resp = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1;
    nvec++; if (m0_resp !== 1'b1) begin nerr++; $display("FAIL rd_T4_m0_resp: got %b want 1", m0_resp); end
    nvec++; if (m0_rdata !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL rd_m0_rdata: got %h want deadbeef", m0_rdata); end
    nvec++; if ({m1_resp, m0_fault} !== 2'b00) begin nerr++; $display("FAIL rd_T4_other: got %b want 00", {m1_resp, m0_fault}); end
    tick();
    s_resp = 1'b0;
    #1;
    nvec++; if ({s_req, m0_resp} !== 2'b00) begin nerr++; $display("FAIL rd_T5_idle: got %b want 00", {s_req, m0_resp}); end
    tick();
    #1;
    nvec++; if (s_req !== 1'b0) begin nerr++; $display("FAIL rd_T6_no_reissue: got %b want 0", s_req); end
  endtask

  task automatic test_round_robin();
    do_reset();
    tick();
    m0_addr = 32'h2000; m0_req = 1'b1;
    m1_addr = 32'h3000; m1_req = 1'b1; m1_w_rb = 1'b0;
    tick();
    m1_req = 1'b0;
    m0_addr = 32'h9999;
    tick();
    m0_req = 1'b0;
    #1;
    nvec++; if ({s_req, s_addr} !== {1'b1, 32'h2000}) begin nerr++; $display("FAIL rr1_m0_first: got %b/%h want 1/00002000", s_req, s_addr); end
    tick();
    s_resp = 1'b1;
    #1;
    nvec++; if ({m0_resp, m1_resp} !== 2'b10) begin nerr++; $display("FAIL rr1_m0_resp: got %b want 10", {m0_resp, m1_resp}); end
    tick();
    s_resp = 1'b0;
    #1;
    nvec++; if (s_req !== 1'b0) begin nerr++; $display("FAIL rr1_gap_idle: got %b want 0", s_req); end
    tick();
    s_resp = 1'b1;
    #1;
    nvec++; if ({s_req, s_addr} !== {1'b1, 32'h3000}) begin nerr++; $display("FAIL rr1_m1_second: got %b/%h want 1/00003000", s_req, s_addr); end
    nvec++; if ({m0_resp, m1_resp} !== 2'b01) begin nerr++; $display("FAIL rr1_m1_zw_resp: got %b want 01", {m0_resp, m1_resp}); end
    tick();
    s_resp = 1'b0;
    #1;
    nvec++; if (s_req !== 1'b0) begin nerr++; $display("FAIL rr1_T6_idle: got %b want 0", s_req); end
    tick();
    #1;
    nvec++; if (s_req !== 1'b0) begin nerr++; $display("FAIL rr1_T7_ignored_req: got %b want 0", s_req); end
    m0_addr = 32'h4000; m0_req = 1'b1;
    m1_addr = 32'h5000; m1_req = 1'b1;
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    s_resp = 1'b1;
    #1;
    nvec++; if ({s_req, s_addr} !== {1'b1, 32'h4000}) begin nerr++; $display("FAIL rr2_m0_third: got %b/%h want 1/00004000", s_req, s_addr); end
    nvec++; if ({m0_resp, m1_resp} !== 2'b10) begin nerr++; $display("FAIL rr2_m0_zw_resp: got %b want 10", {m0_resp, m1_resp}); end
    tick();
    s_resp = 1'b0;
    #1;
    nvec++; if (s_req !== 1'b0) begin nerr++; $display("FAIL rr2_no_wait: got %b want 0", s_req); end
    tick();
    s_resp = 1'b1;
    #1;
    nvec++; if ({s_req, s_addr, m1_resp} !== {1'b1, 32'h5000, 1'b1}) begin nerr++; $display("FAIL rr2_m1_fourth: got %b/%h/%b want 1/00005000/1", s_req, s_addr, m1_resp); end
    tick();
    s_resp = 1'b0;
  endtask

  task automatic test_fault();
    tick();
    m1_addr = 32'hFFFF_0000; m1_w_rb = 1'b1; m1_wdata = 32'hCAFE_F00D; m1_req = 1'b1;
    tick();
    m1_req = 1'b0;
    tick();
    s_fault = 1'b1;
    m0_addr = 32'h6000; m0_w_rb = 1'b0; m0_req = 1'b1;
    #1;
    nvec++; if ({s_req, s_addr, s_w_rb} !== {1'b1, 32'hFFFF_0000, 1'b1}) begin nerr++; $display("FAIL flt_issue: got %b/%h/%b want 1/ffff0000/1", s_req, s_addr, s_w_rb); end
    nvec++; if (s_wdata !== 32'hCAFE_F00D) begin nerr++; $display("FAIL flt_wdata: got %h want cafef00d", s_wdata); end
    nvec++; if ({m1_fault, m0_fault, m1_resp, m0_resp} !== 4'b1000) begin nerr++; $display("FAIL flt_pulse: got %b want 1000", {m1_fault, m0_fault, m1_resp, m0_resp}); end
    tick();
    s_fault = 1'b0; m0_req = 1'b0;
    #1;
    nvec++; if ({s_req, m1_fault} !== 2'b00) begin nerr++; $display("FAIL flt_after: got %b want 00", {s_req, m1_fault}); end
    tick();
    s_resp = 1'b1;
    #1;
    nvec++; if ({s_req, s_addr, m0_resp} !== {1'b1, 32'h6000, 1'b1}) begin nerr++; $display("FAIL flt_m0_served: got %b/%h/%b want 1/00006000/1", s_req, s_addr, m0_resp); end
    tick();
    s_resp = 1'b0;
    tick();
    #1;
    nvec++; if (s_req !== 1'b0) begin nerr++; $display("FAIL flt_pend1_clear: got %b want 0", s_req); end
  endtask

  task automatic test_timeout();
    tick();
    m0_addr = 32'h7000; m0_req = 1'b1;
    tick();
    m0_req = 1'b0;
    tick();
    #1;
    nvec++; if (s_req !== 1'b1) begin nerr++; $display("FAIL to_issue: got %b want 1", s_req); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      #1;
      if (i < 8) begin
        nvec++; if (m0_fault !== 1'b0) begin nerr++; $display("FAIL to_early_%0d: got %b want 0", i, m0_fault); end
      end else begin
        nvec++; if ({m0_fault, m1_fault} !== 2'b10) begin nerr++; $display("FAIL to_fault_c8: got %b want 10", {m0_fault, m1_fault}); end
      end
    end
    tick();
    s_resp = 1'b1;
    #1;
    nvec++; if ({m0_resp, m1_resp} !== 2'b00) begin nerr++; $display("FAIL to_stray_resp: got %b want 00", {m0_resp, m1_resp}); end
    tick();
    s_resp = 1'b0;
    #1;
    nvec++; if (s_req !== 1'b0) begin nerr++; $display("FAIL to_idle: got %b want 0", s_req); end
  endtask

  task automatic test_reset_wait();
    tick();
    m0_addr = 32'h8000; m0_req = 1'b1;
    tick();
    m0_req = 1'b0;
    tick();
    tick();
    tick();
    rstn = 1'b0; s_resp = 1'b1; s_rdata = 32'h0;
    #1;
    nvec++; if ({s_req, m0_resp, m0_fault, m1_resp, m1_fault} !== 5'b0) begin nerr++; $display("FAIL rw_outs: got %b want 00000", {s_req, m0_resp, m0_fault, m1_resp, m1_fault}); end
    nvec++; if ({s_addr, m0_rdata} !== 64'h0) begin nerr++; $display("FAIL rw_data: got %h/%h want 0/0", s_addr, m0_rdata); end
    tick();
    rstn = 1'b1;
    #1;
    nvec++; if ({m0_resp, m1_resp, s_req} !== 3'b000) begin nerr++; $display("FAIL rw_stray: got %b want 000", {m0_resp, m1_resp, s_req}); end
    tick();
    s_resp = 1'b0;
    m1_addr = 32'hA000; m1_w_rb = 1'b0; m1_req = 1'b1;
    tick();
    m1_req = 1'b0;
    tick();
    #1;
    nvec++; if ({s_req, s_addr} !== {1'b1, 32'hA000}) begin nerr++; $display("FAIL rw_m1_issue: got %b/%h want 1/0000a000", s_req, s_addr); end
    tick();
    s_resp = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    nvec++; if ({m1_resp, m0_resp, m1_rdata} !== {2'b10, 32'h1234_5678}) begin nerr++; $display("FAIL rw_m1_resp: got %b%b/%h want 10/12345678", m1_resp, m0_resp, m1_rdata); end
    tick();
    s_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_round_robin();
    test_fault();
    test_timeout();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
